// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// sobel_pkg : shared widths, types and arithmetic helpers for sobel_convolver
// Revision  : 1.0
// ============================================================================
package sobel_pkg;

    localparam int PIXW  = 8;
    localparam int COEFW = 5;
    localparam int ACCW  = 18;
    localparam int PRODW = PIXW + COEFW;

    localparam logic [PIXW-1:0] PIXMAX = {PIXW{1'b1}};

    typedef logic [PIXW-1:0]                 pixel_t;
    typedef logic signed [COEFW-1:0]         coef_t;
    typedef logic [2:0][2:0][PIXW-1:0]       window_t;
    typedef logic [2:0][2:0][COEFW-1:0]      kernel_t;
    typedef logic signed [PRODW-1:0]         prod_t;
    typedef logic signed [ACCW-1:0]          acc_t;

    // Both operands are widened to the product width first, so the truncated
    // product is exact: |255 * -16| still fits in PRODW signed bits.
    function automatic prod_t pix_mul(input pixel_t p, input coef_t c);
        prod_t a;
        prod_t b;
        a = {{(PRODW-PIXW){1'b0}}, p};
        b = {{(PRODW-COEFW){c[COEFW-1]}}, c};
        return a * b;
    endfunction

    function automatic acc_t prod_ext(input prod_t p);
        return {{(ACCW-PRODW){p[PRODW-1]}}, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_convolver_kernel_dot.sv
`default_nettype none
// ============================================================================
// kernel_dot : 3x3 pixel-by-coefficient dot product, products and row sums
//              registered; final three-way sum is combinational.
// Revision   : 1.0
// ============================================================================
module kernel_dot
    import sobel_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  window_t window,
    input  kernel_t kern,
    output acc_t    sum
);

    prod_t r_prod [3][3];
    acc_t  r_row  [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_prod[r][c] <= '0;
                end
                r_row[r] <= '0;
            end
        end else if (en) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_prod[r][c] <= pix_mul(window[r][c], $signed(kern[r][c]));
                end
                r_row[r] <= prod_ext(r_prod[r][0]) + prod_ext(r_prod[r][1])
                          + prod_ext(r_prod[r][2]);
            end
        end
    end

    assign sum = r_row[0] + r_row[1] + r_row[2];

endmodule
`default_nettype wire

// File: rtl/sobel_convolver.sv
`default_nettype none
// ============================================================================
// sobel_convolver : 3-stage Gx/Gy/|Gx|+|Gy| pipeline with valid/ready
//                   handshakes and whole-pipe back-pressure stall.
// Revision        : 1.0
// ============================================================================
module sobel_convolver
    import sobel_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    output logic    in_ready,
    input  window_t window,
    input  kernel_t kx,
    input  kernel_t ky,
    output logic    out_valid,
    input  logic    out_ready,
    output acc_t    gx,
    output acc_t    gy,
    output pixel_t  mag,
    output logic    sat
);

    logic w_en;
    acc_t w_gx;
    acc_t w_gy;

    logic signed [ACCW:0] w_gx_ext;
    logic signed [ACCW:0] w_gy_ext;
    logic [ACCW:0]        w_abs_x;
    logic [ACCW:0]        w_abs_y;
    logic [ACCW:0]        w_abs_sum;
    logic                 w_sat;
    pixel_t               w_mag;

    logic   r_v1;
    logic   r_v2;
    logic   r_out_valid;
    acc_t   r_gx;
    acc_t   r_gy;
    pixel_t r_mag;
    logic   r_sat;

    // A single enable freezes every stage while the output is blocked.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    kernel_dot u_dot_x (
        .clk    (clk),
        .rst    (rst),
        .en     (w_en),
        .window (window),
        .kern   (kx),
        .sum    (w_gx)
    );

    kernel_dot u_dot_y (
        .clk    (clk),
        .rst    (rst),
        .en     (w_en),
        .window (window),
        .kern   (ky),
        .sum    (w_gy)
    );

    always_comb begin
        w_gx_ext  = w_gx;
        w_gy_ext  = w_gy;
        w_abs_x   = (w_gx_ext < 0) ? -w_gx_ext : w_gx_ext;
        w_abs_y   = (w_gy_ext < 0) ? -w_gy_ext : w_gy_ext;
        w_abs_sum = w_abs_x + w_abs_y;
        w_sat     = w_abs_sum > {{(ACCW+1-PIXW){1'b0}}, PIXMAX};
        w_mag     = w_sat ? PIXMAX : w_abs_sum[PIXW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_mag       <= '0;
            r_sat       <= 1'b0;
        end else if (w_en) begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            // Bubbles leave the last result on the outputs untouched.
            if (r_v2) begin
                r_gx  <= w_gx;
                r_gy  <= w_gy;
                r_mag <= w_mag;
                r_sat <= w_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign gx        = r_gx;
    assign gy        = r_gy;
    assign mag       = r_mag;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: doc/sobel_convolver.md
Name: sobel_convolver

Overview:
- Downstream consumer of the kernel generator's two 3x3 coefficient matrices (kx, ky) and of a 3x3 pixel window supplied by the line-buffer stage.
- Computes the gradients Gx and Gy and the magnitude |Gx|+|Gy|, saturated to one pixel, in a 3-stage pipeline.
- Uses valid/ready handshakes on input and output, with full back-pressure stall.
- The result feeds the edge-threshold/output-writer stage.

Parameters:
- PIXW, 8: unsigned pixel width.
- COEFW, 5: two's-complement coefficient width; matches the kernel generator.
- ACCW, 18: signed accumulator width for Gx/Gy. Holds the worst case 9*255*16 plus the sign bit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  window and kernel are valid this cycle.
- in_ready  out  1  block can accept an input this cycle.
- window  in  [2:0][2:0][PIXW-1:0]  pixel window, indexed [row][col], unsigned.
- kx  in  [2:0][2:0][COEFW-1:0]  X kernel, signed, [row][col].
- ky  in  [2:0][2:0][COEFW-1:0]  Y kernel, signed, [row][col].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- gx  out  ACCW  signed sum over r,c of window[r][c]*kx[r][c].
- gy  out  ACCW  signed sum over r,c of window[r][c]*ky[r][c].
- mag  out  PIXW  min(|gx|+|gy|, 2^PIXW-1).
- sat  out  1  set when mag was clipped.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: out_valid=0, gx=0, gy=0, mag=0, sat=0, all internal stage-valid bits=0. in_ready=1 on the first cycle after reset deasserts.
- Handshake: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Global advance: en = !out_valid || out_ready, and in_ready = en.
  - When en=0, every stage register and valid bit holds.
  - Outputs stay stable while out_valid=1 && out_ready=0.
- Stage 1 (on accept):
  - Each pixel is zero-extended to PIXW+1 bits signed and multiplied by the sign-extended coefficient.
  - Produces 18 products of PIXW+COEFW bits, registered.
  - Kernels are sampled only at acceptance; a kx/ky change after accept never affects in-flight data.
- Stage 2: three row partial sums per kernel, sign-extended to ACCW, registered.
- Stage 3:
  - gx and gy are the sums of their row partials.
  - mag is computed from |gx|+|gy| at ACCW+1 bits. If that value exceeds 2^PIXW-1, then mag=2^PIXW-1 and sat=1; otherwise sat=0.
  - Results are registered into the output regs; out_valid is set.
- Latency: exactly 3 cycles from accept to out_valid when unstalled.
- Throughput: 1 result per cycle; bubbles propagate as stage-valid=0.
- No overflow is possible within ACCW for any 5-bit coefficient; there is no wrap-around.
- Stall: a full pipe with out_ready=0 holds all 3 entries; nothing is dropped or duplicated.
- Simultaneous accept and consume with a full pipe proceeds normally (en=1).
- Reset mid-operation: all in-flight data is discarded. out_valid=0 on the cycle after rst is sampled high, and no stale result appears afterwards.
- Inputs while in_ready=0 are ignored. in_valid may drop at any time without affecting in-flight data.

Decomposition:
- Package sobel_pkg:
  - pixel_t (logic [PIXW-1:0])
  - coef_t (logic signed [COEFW-1:0])
  - window_t, kernel_t (the [2:0][2:0] packed arrays)
  - ACCW, and PIXMAX = 2^PIXW-1
- Sub-module kernel_dot: one 3x3 dot product across stages 1-2 plus the final sum. It takes en and produces the ACCW-bit result; it is instantiated twice (X, Y).
- The top level holds the valid pipeline, the abs/saturation logic and the handshake.

Test Plan:
- Flat window (all 100), kernels for bscalar=2, out_ready=1 -> after 3 cycles gx=0, gy=0, mag=0, sat=0.
- Cols 0/0/10 in every row, bscalar=2 -> gx=-40, gy=0, mag=40, sat=0. Cols 0/0/255 -> gx=-1020, gy=0, mag=255, sat=1.
- 3 windows back-to-back with out_ready=0 for 6 cycles:
  - in_ready drops once the pipe is full.
  - The first result is held stable.
  - On release, exactly 3 results appear in order, one per cycle.
- Accept a window with the bscalar=2 kernel, then switch to bscalar=4 on the next cycle -> result uses the bscalar=2 kernel (e.g. gx=-40 above, not -60).
- Assert rst for 1 cycle with 2 windows in flight -> out_valid=0 the next cycle and stays 0 until new input; gx/gy/mag=0.
- Random windows and bscalar 0..15 with random in_valid/out_ready -> outputs match a golden model in order, with no loss or duplication.
